// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: data and register-index widths plus the ROB tag type.
package rv32i_pkg;
  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ROB_WIDTH      = 4;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [ROB_WIDTH-1:0]      rob_id_t;
endpackage

// File: rtl/register_file_if.sv
// Register file bus: ROB commit writes, dispatch renames, flush, and two operand reads with ROB replies.
interface register_file_if #(
  parameter int ROB_WIDTH = rv32i_pkg::ROB_WIDTH
);
  import rv32i_pkg::*;

  logic                 clear;
  logic                 regUpdateValid;
  reg_addr_t            regUpdateDest;
  logic [XLEN-1:0]      regValue;
  logic [ROB_WIDTH-1:0] regUpdateRobId;
  logic                 renameValid;
  reg_addr_t            renameDest;
  logic [ROB_WIDTH-1:0] renameRobId;
  reg_addr_t            rs1Addr;
  reg_addr_t            rs2Addr;
  logic [ROB_WIDTH-1:0] rs1Dep;
  logic [ROB_WIDTH-1:0] rs2Dep;
  logic                 robRs1Ready;
  logic                 robRs2Ready;
  logic [XLEN-1:0]      robRs1Value;
  logic [XLEN-1:0]      robRs2Value;
  logic                 rs1Ready;
  logic                 rs2Ready;
  logic [XLEN-1:0]      rs1Value;
  logic [XLEN-1:0]      rs2Value;

  modport master (
    output clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
           renameValid, renameDest, renameRobId, rs1Addr, rs2Addr,
           robRs1Ready, robRs2Ready, robRs1Value, robRs2Value,
    input  rs1Dep, rs2Dep, rs1Ready, rs2Ready, rs1Value, rs2Value
  );

  modport slave (
    input  clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
           renameValid, renameDest, renameRobId, rs1Addr, rs2Addr,
           robRs1Ready, robRs2Ready, robRs1Value, robRs2Value,
    output rs1Dep, rs2Dep, rs1Ready, rs2Ready, rs1Value, rs2Value
  );
endinterface

// File: rtl/reg_operand_resolve.sv
// Resolves one source operand from x0, the architectural value, a same-cycle commit or the ROB reply.
// The commit bypass exists only when REG_FORWARD_EN is defined.
module reg_operand_resolve #(
  parameter int ROB_WIDTH = rv32i_pkg::ROB_WIDTH
) (
  input  rv32i_pkg::reg_addr_t           addr_i,
  input  logic                           busy_i,
  input  logic [ROB_WIDTH-1:0]           tag_i,
  input  logic [rv32i_pkg::XLEN-1:0]     regValue_i,
  input  logic                           robReady_i,
  input  logic [rv32i_pkg::XLEN-1:0]     robValue_i,
  input  logic                           commitValid_i,
  input  rv32i_pkg::reg_addr_t           commitDest_i,
  input  logic [ROB_WIDTH-1:0]           commitRobId_i,
  input  logic [rv32i_pkg::XLEN-1:0]     commitValue_i,
  output logic                           ready_o,
  output logic [rv32i_pkg::XLEN-1:0]     value_o,
  output logic [ROB_WIDTH-1:0]           dep_o
);
  import rv32i_pkg::*;

  logic fwdHit;

`ifdef REG_FORWARD_EN
  assign fwdHit = commitValid_i && (commitDest_i == addr_i) && busy_i && (tag_i == commitRobId_i);
`else
  logic unusedCommit;
  assign unusedCommit = ^{commitValid_i, commitDest_i, commitRobId_i, commitValue_i};
  assign fwdHit       = 1'b0;
`endif

  // A busy register waits on its producer unless the value arrives by bypass or from the ROB.
  always_comb begin
    ready_o = 1'b1;
    value_o = '0;
    dep_o   = tag_i;
    if (addr_i == REG_ZERO) begin
      dep_o = '0;
    end else if (!busy_i) begin
      value_o = regValue_i;
    end else if (fwdHit) begin
      value_o = commitValue_i;
    end else if (robReady_i) begin
      value_o = robValue_i;
    end else begin
      ready_o = 1'b0;
    end
  end
endmodule

// File: rtl/register_file.sv
// Architectural register file with busy/tag rename table for the RV32I out-of-order core.
// Commit-to-read bypass is controlled by REG_FORWARD_EN (see reg_operand_resolve).
module register_file #(
  parameter int ROB_WIDTH = rv32i_pkg::ROB_WIDTH,
  parameter int REG_COUNT = 32
) (
  input logic            clockIn,
  input logic            resetIn,
  register_file_if.slave bus
);
  import rv32i_pkg::*;

  logic [REG_COUNT-1:0][XLEN-1:0]      regs_q, regs_d;
  logic [REG_COUNT-1:0]                busy_q, busy_d;
  logic [REG_COUNT-1:0][ROB_WIDTH-1:0] tag_q, tag_d;

  logic commitHit;
  logic renameHit;

  assign commitHit = bus.regUpdateValid && (bus.regUpdateDest != REG_ZERO);
  assign renameHit = bus.renameValid && (bus.renameDest != REG_ZERO) && !bus.clear;

  // A commit only frees the register if it is still the newest producer; rename overrides it.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commitHit) begin
      regs_d[bus.regUpdateDest] = bus.regValue;
      if (tag_q[bus.regUpdateDest] == bus.regUpdateRobId) begin
        busy_d[bus.regUpdateDest] = 1'b0;
      end
    end
    if (bus.clear) begin
      busy_d = '0;
      tag_d  = '0;
    end else if (renameHit) begin
      busy_d[bus.renameDest] = 1'b1;
      tag_d[bus.renameDest]  = bus.renameRobId;
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      regs_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  reg_operand_resolve #(.ROB_WIDTH(ROB_WIDTH)) u_rs1 (
    .addr_i        (bus.rs1Addr),
    .busy_i        (busy_q[bus.rs1Addr]),
    .tag_i         (tag_q[bus.rs1Addr]),
    .regValue_i    (regs_q[bus.rs1Addr]),
    .robReady_i    (bus.robRs1Ready),
    .robValue_i    (bus.robRs1Value),
    .commitValid_i (bus.regUpdateValid),
    .commitDest_i  (bus.regUpdateDest),
    .commitRobId_i (bus.regUpdateRobId),
    .commitValue_i (bus.regValue),
    .ready_o       (bus.rs1Ready),
    .value_o       (bus.rs1Value),
    .dep_o         (bus.rs1Dep)
  );

  reg_operand_resolve #(.ROB_WIDTH(ROB_WIDTH)) u_rs2 (
    .addr_i        (bus.rs2Addr),
    .busy_i        (busy_q[bus.rs2Addr]),
    .tag_i         (tag_q[bus.rs2Addr]),
    .regValue_i    (regs_q[bus.rs2Addr]),
    .robReady_i    (bus.robRs2Ready),
    .robValue_i    (bus.robRs2Value),
    .commitValid_i (bus.regUpdateValid),
    .commitDest_i  (bus.regUpdateDest),
    .commitRobId_i (bus.regUpdateRobId),
    .commitValue_i (bus.regValue),
    .ready_o       (bus.rs2Ready),
    .value_o       (bus.rs2Value),
    .dep_o         (bus.rs2Dep)
  );
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios with literal expectations, then random traffic
// compared every cycle against an array-based model of the architectural/rename state.
module tb_register_file;
  import rv32i_pkg::*;

  logic clockIn = 1'b0;
  logic resetIn = 1'b0;
  bit   checkEn = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  register_file_if bus ();

  register_file dut (
    .clockIn (clockIn),
    .resetIn (resetIn),
    .bus     (bus)
  );

  always #5 clockIn = ~clockIn;

  logic [31:0] mRegs [32];
  logic        mBusy [32];
  logic [3:0]  mTag  [32];

  task automatic clearModel();
    for (int i = 0; i < 32; i++) begin
      mRegs[i] = '0;
      mBusy[i] = 1'b0;
      mTag[i]  = '0;
    end
  endtask

  // Architectural state follows the commit/rename/flush rules at every rising edge out of reset.
  always @(posedge clockIn) begin
    if (resetIn) begin
      if (bus.regUpdateValid && bus.regUpdateDest != 5'd0)
        mRegs[bus.regUpdateDest] = bus.regValue;
      if (bus.clear) begin
        for (int i = 0; i < 32; i++) begin
          mBusy[i] = 1'b0;
          mTag[i]  = '0;
        end
      end else begin
        if (bus.regUpdateValid && bus.regUpdateDest != 5'd0 && mTag[bus.regUpdateDest] == bus.regUpdateRobId)
          mBusy[bus.regUpdateDest] = 1'b0;
        if (bus.renameValid && bus.renameDest != 5'd0) begin
          mBusy[bus.renameDest] = 1'b1;
          mTag[bus.renameDest]  = bus.renameRobId;
        end
      end
    end
  end

  function automatic void expectOperand(input logic [4:0] a, input logic robReady, input logic [31:0] robValue,
                                        output logic r, output logic [31:0] v, output logic [3:0] d);
    r = 1'b1;
    v = '0;
    d = '0;
    if (a == 5'd0) return;
    d = mTag[a];
    if (!mBusy[a]) v = mRegs[a];
`ifdef REG_FORWARD_EN
    else if (bus.regUpdateValid && bus.regUpdateDest == a && mTag[a] == bus.regUpdateRobId) v = bus.regValue;
`endif
    else if (robReady) v = robValue;
    else r = 1'b0;
  endfunction

  task automatic compareOperand(input string name, input logic [4:0] a, input logic robReady, input logic [31:0] robValue,
                                input logic aR, input logic [31:0] aV, input logic [3:0] aD);
    logic r;
    logic [31:0] v;
    logic [3:0] d;
    expectOperand(a, robReady, robValue, r, v, d);
    total++;
    if ({aR, aV, aD} !== {r, v, d}) begin
      bad++;
      $display("[TB] FAIL %s x%0d @%0t: dut ready=%0b value=0x%h dep=%0d, required ready=%0b value=0x%h dep=%0d",
               name, a, $time, aR, aV, aD, r, v, d);
    end
  endtask

  // Every cycle, mid-period, both read ports must match the model.
  always @(negedge clockIn) begin
    if (checkEn) begin
      compareOperand("cycle rs1", bus.rs1Addr, bus.robRs1Ready, bus.robRs1Value, bus.rs1Ready, bus.rs1Value, bus.rs1Dep);
      compareOperand("cycle rs2", bus.rs2Addr, bus.robRs2Ready, bus.robRs2Value, bus.rs2Ready, bus.rs2Value, bus.rs2Dep);
    end
  end

  // Literal expectation checked against the DUT and against the model, so the model itself is pinned.
  task automatic checkOutput(input string name, input int sel, input logic expR, input logic [31:0] expV, input logic [3:0] expD);
    logic aR, mR;
    logic [31:0] aV, mV;
    logic [3:0] aD, mD;
    if (sel == 0) begin
      aR = bus.rs1Ready; aV = bus.rs1Value; aD = bus.rs1Dep;
      expectOperand(bus.rs1Addr, bus.robRs1Ready, bus.robRs1Value, mR, mV, mD);
    end else begin
      aR = bus.rs2Ready; aV = bus.rs2Value; aD = bus.rs2Dep;
      expectOperand(bus.rs2Addr, bus.robRs2Ready, bus.robRs2Value, mR, mV, mD);
    end
    total++;
    if ({aR, aV, aD} !== {expR, expV, expD}) begin
      bad++;
      $display("[TB] FAIL %s: dut ready=%0b value=0x%h dep=%0d, required ready=%0b value=0x%h dep=%0d",
               name, aR, aV, aD, expR, expV, expD);
    end
    total++;
    if ({mR, mV, mD} !== {expR, expV, expD}) begin
      bad++;
      $display("[TB] FAIL model %s: model ready=%0b value=0x%h dep=%0d, required ready=%0b value=0x%h dep=%0d",
               name, mR, mV, mD, expR, expV, expD);
    end
  endtask

  task automatic applyStimulus(input logic cV, input logic [4:0] cDest, input logic [31:0] cVal, input logic [3:0] cId,
                               input logic rV, input logic [4:0] rDest, input logic [3:0] rId, input logic clr);
    bus.regUpdateValid = cV;
    bus.regUpdateDest  = cDest;
    bus.regValue       = cVal;
    bus.regUpdateRobId = cId;
    bus.renameValid    = rV;
    bus.renameDest     = rDest;
    bus.renameRobId    = rId;
    bus.clear          = clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 4'd0, 1'b0);
  endtask

  task automatic nextCycle();
    @(posedge clockIn);
    #1;
  endtask

  initial begin
    idle();
    bus.rs1Addr = 5'd0;      bus.rs2Addr = 5'd0;
    bus.robRs1Ready = 1'b0;  bus.robRs2Ready = 1'b0;
    bus.robRs1Value = 32'd0; bus.robRs2Value = 32'd0;
    clearModel();
    repeat (2) @(posedge clockIn);
    #2 resetIn = 1'b1;
    checkEn = 1'b1;

    bus.rs1Addr = 5'd5; bus.rs2Addr = 5'd31;
    #1;
    checkOutput("reset x5", 0, 1'b1, 32'd0, 4'd0);
    checkOutput("reset x31", 1, 1'b1, 32'd0, 4'd0);

    // Asynchronous reset while x5 is busy
    applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd5, 4'd3, 1'b0);
    nextCycle();
    idle();
    #1 checkOutput("busy before reset", 0, 1'b0, 32'd0, 4'd3);
    resetIn = 1'b0;
    clearModel();
    #1 checkOutput("async reset x5", 0, 1'b1, 32'd0, 4'd0);
    #1 resetIn = 1'b1;

    // Rename then ROB reply
    applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd5, 4'd3, 1'b0);
    nextCycle();
    idle();
    bus.rs1Addr = 5'd5; bus.robRs1Ready = 1'b0;
    #1 checkOutput("rename x5 waiting", 0, 1'b0, 32'd0, 4'd3);
    bus.robRs1Ready = 1'b1; bus.robRs1Value = 32'h1234;
    #1 checkOutput("rob reply x5", 0, 1'b1, 32'h1234, 4'd3);
    bus.robRs1Ready = 1'b0;

    // Stale commit keeps the newer producer busy
    applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd5, 4'd3, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd5, 4'd7, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd5, 32'hAA, 4'd3, 1'b0, 5'd0, 4'd0, 1'b0);
    nextCycle();
    idle();
    #1 checkOutput("stale commit x5", 0, 1'b0, 32'd0, 4'd7);

    // Commit and rename of the same register in one cycle
    applyStimulus(1'b1, 5'd6, 32'h55, 4'd2, 1'b1, 5'd6, 4'd9, 1'b0);
    nextCycle();
    idle();
    bus.rs2Addr = 5'd6; bus.robRs2Ready = 1'b0;
    #1 checkOutput("commit+rename x6", 1, 1'b0, 32'd0, 4'd9);

    // Flush with a concurrent (dropped) rename
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'(32'h11 * i), 4'd15, 1'b0, 5'd0, 4'd0, 1'b0);
      nextCycle();
    end
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'(i), 4'(9 + i), 1'b0);
      nextCycle();
    end
    idle();
    bus.rs1Addr = 5'd1;
    #1 checkOutput("x1 busy", 0, 1'b0, 32'd0, 4'd10);
    applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd8, 4'd1, 1'b1);
    nextCycle();
    idle();
    #1 checkOutput("flush x1", 0, 1'b1, 32'h11, 4'd0);
    bus.rs1Addr = 5'd4;
    #1 checkOutput("flush x4", 0, 1'b1, 32'h44, 4'd0);
    bus.rs1Addr = 5'd5;
    #1 checkOutput("flush x5", 0, 1'b1, 32'hAA, 4'd0);
    #1 checkOutput("flush x6", 1, 1'b1, 32'h55, 4'd0);
    bus.rs1Addr = 5'd8;
    #1 checkOutput("flush drops rename x8", 0, 1'b1, 32'd0, 4'd0);

    // x0 ignores commits; commit bypass on x7
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 4'd0, 1'b0, 5'd0, 4'd0, 1'b0);
    nextCycle();
    idle();
    bus.rs1Addr = 5'd0;
    #1 checkOutput("x0 after commit", 0, 1'b1, 32'd0, 4'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd7, 4'd4, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 5'd7, 32'h99, 4'd4, 1'b0, 5'd0, 4'd0, 1'b0);
    bus.rs1Addr = 5'd7; bus.robRs1Ready = 1'b0;
`ifdef REG_FORWARD_EN
    #1 checkOutput("x7 commit cycle", 0, 1'b1, 32'h99, 4'd4);
`else
    #1 checkOutput("x7 commit cycle", 0, 1'b0, 32'd0, 4'd4);
`endif
    nextCycle();
    idle();
    #1 checkOutput("x7 after commit", 0, 1'b1, 32'h99, 4'd4);

    // Random traffic on a narrow register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] cDest;
      logic [3:0] cId;
      cDest = 5'($urandom_range(0, 7));
      cId   = ($urandom_range(0, 1) == 1) ? mTag[cDest] : 4'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), cDest, $urandom, cId,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 19) == 0));
      bus.rs1Addr     = ($urandom_range(0, 2) == 0) ? cDest : 5'($urandom_range(0, 7));
      bus.rs2Addr     = 5'($urandom_range(0, 7));
      bus.robRs1Ready = 1'($urandom_range(0, 1));
      bus.robRs2Ready = 1'($urandom_range(0, 1));
      bus.robRs1Value = $urandom;
      bus.robRs2Value = $urandom;
      nextCycle();
    end

    idle();
    nextCycle();
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
